greenhouse_vent_plant: RTL

Closed-loop companion to the greenhouse temperature controller. It models the vent actuator and the greenhouse thermal plant. It consumes the controller's vent request and produces the signed greenhouse temperature and the "outside warmer than greenhouse" flag that the controller reads. The vent has finite travel time. Temperature drifts toward the outside temperature, quickly when the vent is fully open and slowly (leakage) otherwise. Used in system-level simulation and as an FPGA demo plant.

---
 rtl/greenhouse_pkg.sv | 28 ++
 rtl/greenhouse_step_timer.sv | 35 +++
 rtl/greenhouse_vent_plant.sv | 123 ++++++++++++
 3 files changed

// File: rtl/greenhouse_pkg.sv
// Shared types and constants for the greenhouse controller / plant pair.
// Holds the vent state encodings, temperature width and controller hysteresis.
package greenhouse_pkg;

    localparam int TEMP_W = 8;
    localparam int TH     = 5;

    typedef enum logic [1:0] {
        VENT_CLOSED  = 2'd0,
        VENT_OPENING = 2'd1,
        VENT_OPEN    = 2'd2,
        VENT_CLOSING = 2'd3
    } vent_state_e;

    // One-degree move toward the target; holds when already there.
    function automatic logic signed [TEMP_W-1:0] move_toward(
        input logic signed [TEMP_W-1:0] cur,
        input logic signed [TEMP_W-1:0] target
    );
        if (cur < target) begin
            return cur + 8'sd1;
        end else if (cur > target) begin
            return cur - 8'sd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/greenhouse_step_timer.sv
// Programmable-period tick generator: pulses step_o once every period_i cycles.
// A synchronous clear restarts the count without producing a pulse.
module greenhouse_step_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic [7:0] period_i,
    output logic       step_o
);

    logic [7:0] timer_q;
    logic [7:0] timer_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        timer_d = timer_q + 8'd1;
        step_o  = 1'b0;
        if (clear_i) begin
            timer_d = '0;
        end else if (timer_q == period_i - 8'd1) begin
            timer_d = '0;
            step_o  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/greenhouse_vent_plant.sv
// Vent actuator plus greenhouse thermal plant for closed-loop simulation.
// Optional GREENHOUSE_SOLAR_GAIN_EN adds solar_on, heating the house while the vent is not fully open.
module greenhouse_vent_plant
    import greenhouse_pkg::*;
#(
    parameter int                       TRAVEL_CYCLES = 4,
    parameter int                       OPEN_PERIOD   = 2,
    parameter int                       LEAK_PERIOD   = 16,
    parameter logic signed [TEMP_W-1:0] INIT_TEMP     = 8'sd70
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vent_req,
    input  logic [TEMP_W-1:0] outside_temp,
    input  logic              load,
    input  logic [TEMP_W-1:0] load_temp,
`ifdef GREENHOUSE_SOLAR_GAIN_EN
    input  logic              solar_on,
`endif
    output logic [TEMP_W-1:0] greenhouse_temp,
    output logic              temp_g_greenhouse_temp,
    output logic [1:0]        vent_state,
    output logic              vent_open
);

    localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);

    vent_state_e              state_q, state_d;
    logic [7:0]               tcnt_q, tcnt_d;
    logic                     vent_open_q;
    logic signed [TEMP_W-1:0] temp_q, temp_d;
    logic                     open_edge;
    logic                     timer_clear;
    logic [7:0]               period;
    logic                     step;

    // tcnt counts remaining travel; a reversal restarts from the mirrored position.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            VENT_CLOSED: begin
                if (vent_req) begin
                    state_d = VENT_OPENING;
                    tcnt_d  = TRAVEL_LAST;
                end
            end
            VENT_OPENING: begin
                if (!vent_req) begin
                    state_d = VENT_CLOSING;
                    tcnt_d  = TRAVEL_LAST - tcnt_q;
                end else if (tcnt_q == '0) begin
                    state_d = VENT_OPEN;
                end else begin
                    tcnt_d = tcnt_q - 8'd1;
                end
            end
            VENT_OPEN: begin
                if (!vent_req) begin
                    state_d = VENT_CLOSING;
                    tcnt_d  = TRAVEL_LAST;
                end
            end
            VENT_CLOSING: begin
                if (vent_req) begin
                    state_d = VENT_OPENING;
                    tcnt_d  = TRAVEL_LAST - tcnt_q;
                end else if (tcnt_q == '0) begin
                    state_d = VENT_CLOSED;
                end else begin
                    tcnt_d = tcnt_q - 8'd1;
                end
            end
            default: state_d = VENT_CLOSED;
        endcase
    end

    assign open_edge   = (state_d == VENT_OPEN) != (state_q == VENT_OPEN);
    assign timer_clear = load | open_edge;
    assign period      = (state_q == VENT_OPEN) ? 8'(OPEN_PERIOD) : 8'(LEAK_PERIOD);

    greenhouse_step_timer u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .period_i (period),
        .step_o   (step)
    );

    always_comb begin
        temp_d = temp_q;
        if (load) begin
            temp_d = $signed(load_temp);
        end else if (step) begin
`ifdef GREENHOUSE_SOLAR_GAIN_EN
            if (solar_on && state_q != VENT_OPEN)
                temp_d = (temp_q == 8'sd127) ? temp_q : temp_q + 8'sd1;
            else
`endif
                temp_d = move_toward(temp_q, $signed(outside_temp));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= VENT_CLOSED;
            tcnt_q      <= '0;
            vent_open_q <= 1'b0;
            temp_q      <= INIT_TEMP;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            vent_open_q <= (state_d == VENT_OPEN);
            temp_q      <= temp_d;
        end
    end

    assign greenhouse_temp        = temp_q;
    assign temp_g_greenhouse_temp = $signed(outside_temp) > temp_q;
    assign vent_state             = state_q;
    assign vent_open              = vent_open_q;

endmodule
